// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU port and a loader port share one synchronous memory.
// Each access runs IDLE -> ACC -> RESP -> DONE, and the winner gets a one-cycle ack in DONE.
//
// state  | meaning
// IDLE   | arbitrate between c_req and l_req
// ACC    | drive memory strobe from the captured request
// RESP   | memory read data valid, capture into the winner's rdata
// DONE   | one-cycle ack to the winner
module mem_arbiter (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_c_req,
    input  logic       i_c_we,
    input  logic       i_c_lock,
    input  logic [7:0] i_c_addr,
    input  logic [7:0] i_c_wdata,
    output logic [7:0] o_c_rdata,
    output logic       o_c_ack,
    input  logic       i_l_req,
    input  logic       i_l_we,
    input  logic [7:0] i_l_addr,
    input  logic [7:0] i_l_wdata,
    output logic [7:0] o_l_rdata,
    output logic       o_l_ack,
    output logic       o_m_en,
    output logic       o_m_we,
    output logic [7:0] o_m_addr,
    output logic [7:0] o_m_wdata,
    input  logic [7:0] i_m_rdata,
    output logic       o_busy,
    output logic       o_owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_grant;
    logic       w_win_l;
    logic       w_lock_active;
    logic       r_owner;
    logic [2:0] r_lock_cnt;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_c_rdata;
    logic [7:0] r_l_rdata;

    // Lock only holds while the CPU keeps asking and has not used up its burst of 4.
    assign w_lock_active = (r_lock_cnt != 3'd0) && (r_lock_cnt < 3'd4) && i_c_req;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_win_l = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_c_req || i_l_req) begin
                    w_grant = 1'b1;
                    w_next  = S_ACC;
                    if (!i_l_req) begin
                        w_win_l = 1'b0;
                    end else if (!i_c_req) begin
                        w_win_l = 1'b1;
                    end else if (w_lock_active) begin
                        w_win_l = 1'b0;
                    end else if (r_lock_cnt == 3'd4) begin
                        w_win_l = 1'b1;
                    end else begin
                        w_win_l = ~r_owner;
                    end
                end
            end
            S_ACC:   w_next = S_RESP;
            S_RESP:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner    <= 1'b1;
            r_lock_cnt <= 3'd0;
            r_we       <= 1'b0;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_c_rdata  <= 8'h00;
            r_l_rdata  <= 8'h00;
        end else begin
            if (w_grant) begin
                r_owner <= w_win_l;
                r_we    <= w_win_l ? i_l_we    : i_c_we;
                r_addr  <= w_win_l ? i_l_addr  : i_c_addr;
                r_wdata <= w_win_l ? i_l_wdata : i_c_wdata;
                // A CPU grant at the saturated count means the loader was idle: start a new burst.
                if (w_win_l || !i_c_lock) begin
                    r_lock_cnt <= 3'd0;
                end else if (r_lock_cnt == 3'd4) begin
                    r_lock_cnt <= 3'd1;
                end else begin
                    r_lock_cnt <= r_lock_cnt + 3'd1;
                end
            end else if ((r_state == S_IDLE) && !i_c_req) begin
                r_lock_cnt <= 3'd0;
            end

            if ((r_state == S_RESP) && !r_we) begin
                if (r_owner) begin
                    r_l_rdata <= i_m_rdata;
                end else begin
                    r_c_rdata <= i_m_rdata;
                end
            end
        end
    end

    assign o_m_en    = (r_state == S_ACC);
    assign o_m_we    = (r_state == S_ACC) && r_we;
    assign o_m_addr  = r_addr;
    assign o_m_wdata = r_wdata;
    assign o_c_ack   = (r_state == S_DONE) && !r_owner;
    assign o_l_ack   = (r_state == S_DONE) && r_owner;
    assign o_c_rdata = r_c_rdata;
    assign o_l_rdata = r_l_rdata;
    assign o_busy    = (r_state != S_IDLE);
    assign o_owner   = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus hand-written
// sequences for round-robin, CPU burst lock, reset mid-access and input changes after grant.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       c_req, c_we, c_lock, c_ack;
    logic [7:0] c_addr, c_wdata, c_rdata;
    logic       l_req, l_we, l_ack;
    logic [7:0] l_addr, l_wdata, l_rdata;
    logic       m_en, m_we;
    logic [7:0] m_addr, m_wdata, m_rdata;
    logic       busy, owner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_c_req   (c_req),
        .i_c_we    (c_we),
        .i_c_lock  (c_lock),
        .i_c_addr  (c_addr),
        .i_c_wdata (c_wdata),
        .o_c_rdata (c_rdata),
        .o_c_ack   (c_ack),
        .i_l_req   (l_req),
        .i_l_we    (l_we),
        .i_l_addr  (l_addr),
        .i_l_wdata (l_wdata),
        .o_l_rdata (l_rdata),
        .o_l_ack   (l_ack),
        .o_m_en    (m_en),
        .o_m_we    (m_we),
        .o_m_addr  (m_addr),
        .o_m_wdata (m_wdata),
        .i_m_rdata (m_rdata),
        .o_busy    (busy),
        .o_owner   (owner)
    );

    function automatic logic [7:0] preset(input logic [7:0] a);
        case (a)
            8'h10:   return 8'hA5;
            8'h20:   return 8'h11;
            8'h21:   return 8'h22;
            8'h22:   return 8'h33;
            8'h23:   return 8'h44;
            8'h55:   return 8'h66;
            default: return 8'h00;
        endcase
    endfunction

    // Synchronous memory: read data appears the cycle after the strobe.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= preset(8'(i));
            m_rdata <= 8'h00;
        end else if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            m_rdata <= mem[m_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        c_req = 1'b0;
        l_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Returns port of the next ack (0 cpu, 1 loader, 2 both, -1 none) and cycles waited.
    task automatic wait_ack(output int p, output int cyc);
        p   = -1;
        cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (c_ack && l_ack) begin p = 2; cyc = i; break; end
            else if (c_ack)     begin p = 0; cyc = i; break; end
            else if (l_ack)     begin p = 1; cyc = i; break; end
        end
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_mine;
        logic [7:0] exp_other;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int         en_cyc, ack_cyc;
        logic [7:0] sa, swd;
        logic       swe;
        bit         oth;
        en_cyc = 0; ack_cyc = 0; sa = 8'h00; swd = 8'h00; swe = 1'b0; oth = 1'b0;
        if (v.port) begin
            c_req = 1'b0;
            l_we = v.we; l_addr = v.addr; l_wdata = v.wdata; l_req = 1'b1;
        end else begin
            l_req = 1'b0; c_lock = 1'b0;
            c_we = v.we; c_addr = v.addr; c_wdata = v.wdata; c_req = 1'b1;
        end
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (m_en && en_cyc == 0) begin
                en_cyc = i; sa = m_addr; swe = m_we; swd = m_wdata;
            end
            if (v.port ? c_ack : l_ack) oth = 1'b1;
            if (v.port ? l_ack : c_ack) begin ack_cyc = i; break; end
        end
        c_req = 1'b0;
        l_req = 1'b0;
        chk($sformatf("v%0d m_en cycle", idx), en_cyc, 1);
        chk($sformatf("v%0d ack cycle", idx), ack_cyc, 3);
        chk($sformatf("v%0d m_addr", idx), sa, v.addr);
        chk($sformatf("v%0d m_we", idx), swe, v.we);
        if (v.we) chk($sformatf("v%0d m_wdata", idx), swd, v.wdata);
        chk($sformatf("v%0d other ack", idx), oth, 0);
        chk($sformatf("v%0d own rdata", idx), v.port ? l_rdata : c_rdata, v.exp_mine);
        chk($sformatf("v%0d other rdata", idx), v.port ? c_rdata : l_rdata, v.exp_other);
        chk($sformatf("v%0d owner", idx), owner, v.port);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];
    int   exp_lock[14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int   rd_exp[4]    = '{'h11, 'h22, 'h33, 'h44};
    int   p, cyc, rd_idx;
    bit   saw_ack;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        c_req = 0; c_we = 0; c_lock = 0; c_addr = 0; c_wdata = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
        //           port  we    addr   wdata  mine   other
        vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 8'hFF, 8'h3C, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h3C, 8'hA5};
        vecs[3] = '{1'b0, 1'b1, 8'h30, 8'h99, 8'hA5, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 8'h30, 8'h00, 8'h99, 8'h3C};
        vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h99};
        vecs[6] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C, 8'hA5};

        do_reset();
        chk("reset busy", busy, 0);
        chk("reset owner", owner, 1);
        chk("reset c_rdata", c_rdata, 0);
        chk("reset l_rdata", l_rdata, 0);
        chk("reset m_en", m_en, 0);
        chk("reset m_addr", m_addr, 0);
        chk("reset acks", {c_ack, l_ack}, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Round-robin with both ports requesting continuously.
        do_reset();
        c_lock = 0; c_we = 0; c_addr = 8'h10; l_we = 0; l_addr = 8'h20;
        c_req = 1; l_req = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(p, cyc);
            chk($sformatf("rr ack%0d port", k), p, k % 2);
            chk($sformatf("rr ack%0d spacing", k), cyc, (k == 0) ? 3 : 4);
            if (p == 0) chk($sformatf("rr ack%0d c_rdata", k), c_rdata, 'hA5);
            if (p == 1) chk($sformatf("rr ack%0d l_rdata", k), l_rdata, 'h11);
        end
        c_req = 0; l_req = 0;
        @(posedge clk);
        #1;

        // CPU burst lock: 4 CPU wins, loader, 5 CPU wins (restart), 3 more CPU, loader.
        do_reset();
        c_lock = 1; c_we = 0; c_addr = 8'h20; l_we = 0; l_addr = 8'h55;
        c_req = 1; l_req = 1;
        rd_idx = 0;
        for (int k = 0; k < 14; k++) begin
            wait_ack(p, cyc);
            chk($sformatf("lock ack%0d port", k), p, exp_lock[k]);
            chk($sformatf("lock ack%0d spacing", k), cyc, (k == 0) ? 3 : 4);
            if (p == 0) begin
                chk($sformatf("lock ack%0d c_rdata", k), c_rdata, rd_exp[rd_idx % 4]);
                rd_idx++;
                c_addr = 8'h20 + 8'(rd_idx % 4);
            end else if (p == 1) begin
                chk($sformatf("lock ack%0d l_rdata", k), l_rdata, 'h66);
            end
            if (k == 4) l_req = 0;
            if (k == 9) l_req = 1;
        end
        c_req = 0; l_req = 0; c_lock = 0;
        @(posedge clk);
        #1;

        // Reset while a CPU read sits in RESP.
        c_we = 0; c_addr = 8'h21; c_req = 1;
        @(posedge clk);
        #1;
        chk("rst-mid m_en in ACC", m_en, 1);
        @(posedge clk);
        #1;
        chk("rst-mid busy in RESP", busy, 1);
        reset = 1; c_req = 0;
        @(posedge clk);
        #1 reset = 0;
        chk("rst-mid c_rdata", c_rdata, 0);
        chk("rst-mid busy", busy, 0);
        chk("rst-mid m_en", m_en, 0);
        chk("rst-mid owner", owner, 1);
        saw_ack = c_ack || l_ack;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (c_ack || l_ack) saw_ack = 1;
        end
        chk("rst-mid no ack", saw_ack, 0);
        begin
            vec_t rv;
            rv = '{1'b0, 1'b0, 8'h21, 8'h00, 8'h22, 8'h00};
            run_vec(rv, 100);
        end

        // Address changed the cycle after grant must not affect the access.
        c_we = 0; c_addr = 8'h10; l_req = 0; c_req = 1;
        @(posedge clk);
        #1;
        c_addr = 8'h55;
        #1;
        chk("late-addr m_en", m_en, 1);
        chk("late-addr m_addr", m_addr, 'h10);
        wait_ack(p, cyc);
        chk("late-addr ack port", p, 0);
        chk("late-addr ack cycle", cyc, 2);
        chk("late-addr c_rdata", c_rdata, 'hA5);
        c_req = 0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge; reset  in  1  synchronous, active-high.
REQ-002 SHALL have CPU port: c_req in 1 request; c_we in 1 write; c_lock in 1 burst lock; c_addr in 8; c_wdata in 8; c_rdata out 8; c_ack out 1 completion pulse.
REQ-003 SHALL have loader port: l_req in 1; l_we in 1; l_addr in 8; l_wdata in 8; l_rdata out 8; l_ack out 1.
REQ-004 SHALL have memory port: m_en out 1 access strobe; m_we out 1; m_addr out 8; m_wdata out 8; m_rdata in 8, valid the cycle after m_en=1 with m_we=0.
REQ-005 SHALL have status outputs: busy out 1, high in any state but IDLE; owner out 1, 0=CPU, 1=loader, last granted port.
REQ-006 Clocking and reset SHALL be one clock, clk; reset synchronous and active-high.

Function
REQ-007 FSM states SHALL be IDLE, ACC, RESP, DONE; transitions IDLE->ACC on grant, ACC->RESP, RESP->DONE, DONE->IDLE, all unconditional except the grant.
REQ-008 Arbitration SHALL occur only in IDLE, sampling c_req and l_req.
REQ-009 Only one request pending: that port SHALL be granted.
REQ-010 Both pending, no lock active: port not equal to owner SHALL win (round-robin).
REQ-011 Lock active: CPU SHALL win regardless of l_req. Lock is active when the previous grant was CPU with c_lock=1, c_req=1 in IDLE, and lock_cnt<4.
REQ-012 lock_cnt (3 bits, saturating at 4) SHALL increment on each CPU grant with c_lock=1. It SHALL clear on any loader grant or any CPU grant with c_lock=0. It SHALL clear in IDLE when c_req=0.
REQ-013 lock_cnt=4 with l_req=1: loader SHALL win. With l_req=0: CPU SHALL be granted and lock_cnt SHALL restart at 1.
REQ-014 On grant, the winner's addr, we and wdata SHALL be registered. owner SHALL update. Later changes on requester inputs SHALL not affect the access in flight.
REQ-015 ACC: m_en=1; m_we, m_addr and m_wdata SHALL come from the registered values. In all other states m_en=0 and m_we=0.
REQ-016 RESP: for a read, m_rdata SHALL be captured into the winner's rdata register. The other port's rdata SHALL be unchanged. Writes SHALL leave both rdata registers unchanged.
REQ-017 DONE: the winner's ack SHALL be 1 for exactly this cycle, reads and writes alike; the other ack SHALL be 0. rdata is valid in the ack cycle and held until that port's next read completes.
REQ-018 Latency: grant in IDLE at cycle T gives m_en at T+1, capture at T+2 and ack at T+3. Minimum repeat period is 4 cycles.
REQ-019 Requester protocol: hold req and its inputs stable until ack. Req still high in the IDLE after DONE SHALL be treated as a new request (back-to-back).
REQ-020 Request withdrawn before grant SHALL be ignored. Withdrawal after grant SHALL not abort the access.
REQ-021 Address arithmetic SHALL be none; addr passes through unmodified. There is no wrap handling; 0xFF is an ordinary address.

Reset
REQ-022 reset=1 at any edge SHALL force IDLE, lock_cnt=0, owner=1 (so CPU wins the first tie), c_rdata=l_rdata=0x00, and registered addr/wdata/we=0.
REQ-023 Reset during ACC/RESP/DONE SHALL abort the access with no ack. m_en SHALL be 0 from the cycle after the reset edge. A write issued in ACC before reset may have occurred.
REQ-024 All outputs SHALL be driven from registers or state decode only, with no combinational path from requester inputs to ack.

Verification
REQ-025 Scenario 1: after reset, c_req=1, c_we=0, c_addr=0x10, mem[0x10]=0xA5 -> m_en=1, m_addr=0x10 at T+1; c_ack=1, c_rdata=0xA5 at T+3; owner=0.
REQ-026 Scenario 2: after reset, c_req=l_req=1 every cycle, c_lock=0 -> grants alternate CPU, loader, CPU, loader; acks 4 cycles apart.
REQ-027 Scenario 3: c_lock=1 with 4 back-to-back CPU reads of 0x20..0x23 while l_req=1 -> 4 consecutive c_acks, then the loader is granted. Then: same stimulus with l_req=0 -> a 5th CPU grant follows.
REQ-028 Scenario 4: l_req=1, l_we=1, l_addr=0xFF, l_wdata=0x3C -> m_we=1, m_addr=0xFF, m_wdata=0x3C in ACC; l_ack at T+3; l_rdata and c_rdata unchanged.
REQ-029 Scenario 5: reset asserted during RESP of a CPU read -> no c_ack, c_rdata=0x00, busy=0 the next cycle, and the next request is served normally.
REQ-030 Scenario 6: c_addr changed from 0x10 to 0x55 one cycle after grant -> m_addr=0x10 in ACC and the data returned is from 0x10.
